// File: rtl/uart_pkg.sv
// uart_pkg - shared types and constants for the UART receiver (rev 1.0)
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync_ff.sv
// sync_ff - multi-stage synchronizer with configurable preset value (rev 1.0)
`default_nettype none

module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART receiver with midpoint sampling (rev 1.0)
// Define UART_RX_FRAME_ERR_EN to add the rx_frame_err strobe output.
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_serial,
  output logic [UART_DATA_BITS-1:0] rx_byte,
`ifdef UART_RX_FRAME_ERR_EN
  output logic                      rx_frame_err,
`endif
  output logic                      rx_dv
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic rxs;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rxs)
  );

  rx_state_t                 state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [IDX_W-1:0]          idx, idx_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic [UART_DATA_BITS-1:0] byte_n;
  logic                      dv_n;
`ifdef UART_RX_FRAME_ERR_EN
  logic                      ferr_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      rx_byte <= '0;
      rx_dv   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      rx_byte <= byte_n;
      rx_dv   <= dv_n;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= ferr_n;
    end
  end
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    byte_n  = rx_byte;
    dv_n    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_n  = 1'b0;
`endif

    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rxs) begin
          state_n = START;
        end
      end

      START: begin
        // A line that is high again at the start-bit midpoint was only a glitch.
        if (cnt == HALF_CNT) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = rxs ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt == BIT_CNT) begin
          cnt_n        = '0;
          shift_n[idx] = rxs;
          if (idx == LAST_IDX) begin
            state_n = STOP;
          end else begin
            idx_n = idx + IDX_ONE;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      STOP: begin
        // Leaving at the stop-bit midpoint leaves half a bit to catch the next start edge.
        if (cnt == BIT_CNT) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rxs) begin
            byte_n = shift;
            dv_n   = 1'b1;
          end else begin
`ifdef UART_RX_FRAME_ERR_EN
            ferr_n = 1'b1;
`endif
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx - directed self-checking bench for uart_rx (rev 1.0)
`default_nettype none

module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB   = 16;
  localparam int SYNC  = 2;
  localparam int HALF  = (CPB - 1) / 2;
  localparam int LAT   = SYNC + HALF + 9 * CPB + 1;

  logic       clk;
  logic       rst;
  logic       rx_serial;
  logic [7:0] rx_byte;
  logic       rx_dv;
`ifdef UART_RX_FRAME_ERR_EN
  logic       rx_frame_err;
`endif

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (rx_serial),
    .rx_byte      (rx_byte),
`ifdef UART_RX_FRAME_ERR_EN
    .rx_frame_err (rx_frame_err),
`endif
    .rx_dv        (rx_dv)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Passive monitor of the output strobe and byte.
  int         dv_count   = 0;
  int         ferr_count = 0;
  int         consec_err = 0;
  int         hold_err   = 0;
  int         dv_cyc     = 0;
  logic [7:0] dv_q[$];
  logic       prev_dv    = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  always @(negedge clk) begin
    if (rx_dv === 1'b1) begin
      dv_count++;
      dv_cyc = cyc;
      dv_q.push_back(rx_byte);
      if (prev_dv === 1'b1) consec_err++;
    end else if (rst === 1'b0 && rx_byte !== prev_byte) begin
      hold_err++;
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (rx_frame_err === 1'b1) ferr_count++;
`endif
    prev_dv   = rx_dv;
    prev_byte = rx_byte;
  end

  int start_cyc = 0;

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx_serial = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_serial = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    n_checks++;
    if (rx_dv !== 1'b0) begin
      n_fail++; $display("FAIL reset_dv: got %b expected 0", rx_dv);
    end
    n_checks++;
    if (rx_byte !== 8'h00) begin
      n_fail++; $display("FAIL reset_byte: got %h expected 00", rx_byte);
    end
    n_checks++;
    if (dv_count !== 0) begin
      n_fail++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", dv_count);
    end
  endtask

  task automatic test_single_byte();
    int lat;
    send_byte(8'h41, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (dv_count !== 1) begin
      n_fail++; $display("FAIL byte41_count: got %0d pulses expected 1", dv_count);
    end
    n_checks++;
    if (rx_byte !== 8'h41 || dv_q.size() < 1 || dv_q[0] !== 8'h41) begin
      n_fail++; $display("FAIL byte41_value: got %h expected 41", rx_byte);
    end
    lat = dv_cyc - start_cyc - 1;
    n_checks++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      n_fail++; $display("FAIL byte41_latency: got %0d cycles expected %0d +/-1", lat, LAT);
    end
  endtask

  task automatic test_second_byte();
    repeat (50) @(negedge clk);
    n_checks++;
    if (rx_byte !== 8'h41) begin
      n_fail++; $display("FAIL byte42_hold_before: got %h expected 41", rx_byte);
    end
    send_byte(8'h42, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (dv_count !== 2 || rx_byte !== 8'h42) begin
      n_fail++; $display("FAIL byte42: got %0d pulses byte %h expected 2 pulses byte 42", dv_count, rx_byte);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (dv_count !== 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d pulses expected 4", dv_count);
    end
    n_checks++;
    if (dv_q.size() != 4 || dv_q[2] !== 8'h00 || dv_q[3] !== 8'hFF) begin
      n_fail++; $display("FAIL b2b_values: got %0d entries last byte %h expected 00 then ff", dv_q.size(), rx_byte);
    end
  endtask

  task automatic test_glitch();
    repeat (20) @(negedge clk);
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if (dv_count !== 4) begin
      n_fail++; $display("FAIL glitch_no_dv: got %0d pulses expected 4", dv_count);
    end
    n_checks++;
    if (dut.state !== IDLE) begin
      n_fail++; $display("FAIL glitch_idle: got state %0d expected %0d", dut.state, IDLE);
    end
    send_byte(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (dv_count !== 5 || rx_byte !== 8'h55) begin
      n_fail++; $display("FAIL glitch_next_byte: got %0d pulses byte %h expected 5 pulses byte 55", dv_count, rx_byte);
    end
  endtask

  task automatic test_frame_error();
    repeat (20) @(negedge clk);
    send_byte(8'hA5, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    n_checks++;
    if (dv_count !== 5) begin
      n_fail++; $display("FAIL ferr_no_dv: got %0d pulses expected 5", dv_count);
    end
    n_checks++;
    if (rx_byte !== 8'h55) begin
      n_fail++; $display("FAIL ferr_byte_hold: got %h expected 55", rx_byte);
    end
`ifdef UART_RX_FRAME_ERR_EN
    n_checks++;
    if (ferr_count !== 1) begin
      n_fail++; $display("FAIL ferr_pulse: got %0d pulses expected 1", ferr_count);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_serial = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (rx_byte !== 8'h00 || rx_dv !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got byte %h dv %b expected 00 0", rx_byte, rx_dv);
    end
    n_checks++;
    if (dut.state !== IDLE) begin
      n_fail++; $display("FAIL midreset_state: got %0d expected %0d", dut.state, IDLE);
    end
    @(negedge clk);
    rx_serial = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    n_checks++;
    if (dv_count !== 5 || rx_byte !== 8'h00) begin
      n_fail++; $display("FAIL midreset_discard: got %0d pulses byte %h expected 5 pulses byte 00", dv_count, rx_byte);
    end
    send_byte(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (dv_count !== 6 || rx_byte !== 8'h3C) begin
      n_fail++; $display("FAIL midreset_recover: got %0d pulses byte %h expected 6 pulses byte 3c", dv_count, rx_byte);
    end
  endtask

  task automatic test_strobe_rules();
    n_checks++;
    if (consec_err !== 0) begin
      n_fail++; $display("FAIL dv_consecutive: got %0d events expected 0", consec_err);
    end
    n_checks++;
    if (hold_err !== 0) begin
      n_fail++; $display("FAIL byte_hold: got %0d changes without dv expected 0", hold_err);
    end
  endtask

  initial begin
    rst       = 1'b1;
    rx_serial = 1'b1;
    test_reset();
    test_single_byte();
    test_second_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_strobe_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
